i2c_slave: RTL

I2C target (responder) for a single 7-bit address; the counterpart of the team's `i2c_master` on the same two-wire bus. Decodes START/STOP/repeated START, matches the address, and ACKs writes, delivering each received byte on a one-cycle strobe. Reads are served from a byte-request handshake, stretching SCL when the host logic is late. Drives open-drain style `sda_out`/`scl_out` (0 = pull low, 1 = release).

---
 rtl/i2c_slave.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// I2C target for one 7-bit address: ACKs writes (rx_stb per byte), serves reads via tx_req/tx_vld.
// Bus reaction 3 clk after an edge; stretches SCL in TXLD until the host supplies a byte.
module i2c_slave #(
  parameter logic [6:0] ADDR    = 7'h50,
  parameter int         SU_DATA = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic       scl_in,
  output logic       scl_out,
  output logic [7:0] rx_dat,
  output logic       rx_stb,
  input  logic [7:0] tx_dat,
  input  logic       tx_vld,
  output logic       tx_req,
  output logic       sel,
  output logic       rd,
  output logic       mnack
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AACK, S_WRX, S_WACK, S_TXLD, S_RTX, S_RACK
  } state_t;

  state_t      state, state_nxt;
  logic        sda_m, sda_s, sda_p, scl_m, scl_s, scl_p;
  logic [7:0]  shreg, shreg_nxt, tx_sh, tx_sh_nxt, hold, hold_nxt, rx_dat_nxt;
  logic        held, held_nxt, ld, ld_nxt;
  logic [3:0]  bcnt, bcnt_nxt;
  logic [7:0]  su_cnt, su_nxt;
  logic        sda_nxt, scl_nxt, rx_stb_nxt, tx_req_nxt, sel_nxt, rd_nxt, mnack_nxt;

  logic start_det, stop_det, scl_rise, scl_fall, tx_take, held_eff, enter_tx;
  logic [7:0] byte_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_m <= 1'b1; sda_s <= 1'b1; sda_p <= 1'b1;
      scl_m <= 1'b1; scl_s <= 1'b1; scl_p <= 1'b1;
    end else begin
      sda_m <= sda_in; sda_s <= sda_m; sda_p <= sda_s;
      scl_m <= scl_in; scl_s <= scl_m; scl_p <= scl_s;
    end
  end

  assign start_det = scl_s & sda_p & ~sda_s;
  assign stop_det  = scl_s & ~sda_p & sda_s;
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign tx_take   = tx_vld & tx_req;
  // A byte offered in the same cycle as the falling edge counts as already held.
  assign held_eff  = held | tx_take;
  assign byte_eff  = held ? hold : tx_dat;
  assign enter_tx  = scl_fall & (((state == S_AACK) & rd) | (state == S_RACK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_det)     state_nxt = S_ADDR;
    else if (stop_det) state_nxt = S_IDLE;
    else begin
      case (state)
        S_ADDR: if (scl_fall && bcnt == 4'd8)
                  state_nxt = (shreg[7:1] == ADDR) ? S_AACK : S_IDLE;
        S_AACK: if (scl_fall)
                  state_nxt = !rd ? S_WRX : (held_eff ? S_RTX : S_TXLD);
        S_WRX:  if (scl_fall && bcnt == 4'd8) state_nxt = S_WACK;
        S_WACK: if (scl_fall) state_nxt = S_WRX;
        S_TXLD: if (ld && su_cnt == '0) state_nxt = S_RTX;
        S_RTX:  if (scl_fall && bcnt == 4'd7) state_nxt = S_RACK;
        S_RACK: begin
          if (scl_rise && sda_s) state_nxt = S_IDLE;
          else if (scl_fall)     state_nxt = held_eff ? S_RTX : S_TXLD;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sda_nxt    = sda_out;
    scl_nxt    = scl_out;
    rx_dat_nxt = rx_dat;
    rx_stb_nxt = 1'b0;
    tx_req_nxt = tx_req;
    sel_nxt    = sel;
    rd_nxt     = rd;
    mnack_nxt  = mnack;
    shreg_nxt  = shreg;
    tx_sh_nxt  = tx_sh;
    hold_nxt   = hold;
    held_nxt   = held;
    ld_nxt     = ld;
    bcnt_nxt   = bcnt;
    su_nxt     = su_cnt;
    if (tx_take) begin
      hold_nxt   = tx_dat;
      held_nxt   = 1'b1;
      tx_req_nxt = 1'b0;
    end
    if (start_det) begin
      bcnt_nxt = '0; sel_nxt = 1'b0; mnack_nxt = 1'b0; sda_nxt = 1'b1;
      scl_nxt = 1'b1; tx_req_nxt = 1'b0; held_nxt = 1'b0; ld_nxt = 1'b0;
    end else if (stop_det) begin
      sel_nxt = 1'b0; tx_req_nxt = 1'b0; sda_nxt = 1'b1; scl_nxt = 1'b1; ld_nxt = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_WRX: begin
          if (scl_rise) begin
            shreg_nxt = {shreg[6:0], sda_s};
            bcnt_nxt  = bcnt + 4'd1;
          end
          if (scl_fall && bcnt == 4'd8) begin
            if (state == S_WRX) begin
              rx_dat_nxt = shreg;
              rx_stb_nxt = 1'b1;
              sda_nxt    = 1'b0;
            end else if (shreg[7:1] == ADDR) begin
              sda_nxt    = 1'b0;
              sel_nxt    = 1'b1;
              rd_nxt     = shreg[0];
              tx_req_nxt = shreg[0];
            end
          end
        end
        S_AACK, S_WACK: if (scl_fall && !(state == S_AACK && rd)) begin
          sda_nxt  = 1'b1;
          bcnt_nxt = '0;
        end
        S_TXLD: begin
          if (!ld && tx_take) begin
            tx_sh_nxt = tx_dat;
            sda_nxt   = tx_dat[7];
            held_nxt  = 1'b0;
            ld_nxt    = 1'b1;
            bcnt_nxt  = '0;
            su_nxt    = 8'(SU_DATA - 1);
          end else if (ld) begin
            if (su_cnt == '0) begin
              scl_nxt = 1'b1;
              ld_nxt  = 1'b0;
            end else begin
              su_nxt = su_cnt - 8'd1;
            end
          end
        end
        S_RTX: if (scl_fall) begin
          if (bcnt == 4'd7) begin
            sda_nxt = 1'b1;
          end else begin
            sda_nxt   = tx_sh[6];
            tx_sh_nxt = {tx_sh[6:0], 1'b0};
            bcnt_nxt  = bcnt + 4'd1;
          end
        end
        S_RACK: if (scl_rise) begin
          if (sda_s) begin
            mnack_nxt = 1'b1;
            sel_nxt   = 1'b0;
          end else begin
            tx_req_nxt = 1'b1;
          end
        end
        default: ;
      endcase
      // Next read byte: drive bit7 straight away if one is held, otherwise stretch.
      if (enter_tx) begin
        if (held_eff) begin
          tx_sh_nxt = byte_eff;
          sda_nxt   = byte_eff[7];
          held_nxt  = 1'b0;
          bcnt_nxt  = '0;
        end else begin
          scl_nxt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_out <= 1'b1; scl_out <= 1'b1; rx_dat <= '0; rx_stb <= 1'b0;
      tx_req <= 1'b0; sel <= 1'b0; rd <= 1'b0; mnack <= 1'b0;
      shreg <= '0; tx_sh <= '0; hold <= '0; held <= 1'b0; ld <= 1'b0;
      bcnt <= '0; su_cnt <= '0;
    end else begin
      sda_out <= sda_nxt; scl_out <= scl_nxt; rx_dat <= rx_dat_nxt; rx_stb <= rx_stb_nxt;
      tx_req <= tx_req_nxt; sel <= sel_nxt; rd <= rd_nxt; mnack <= mnack_nxt;
      shreg <= shreg_nxt; tx_sh <= tx_sh_nxt; hold <= hold_nxt; held <= held_nxt;
      ld <= ld_nxt; bcnt <= bcnt_nxt; su_cnt <= su_nxt;
    end
  end

endmodule
